serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit: one DIGIT-wide slice per cycle, LSB first,
// with carry, borrow and signed-overflow flags committed together on done.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] KLAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, res_r, res_nxt;
    logic             sub_r, carry;
    logic [CW-1:0]    k;
    logic [DIGIT-1:0] ad, bd;
    logic [DIGIT:0]   dsum;
    logic             msb_cin, accept, last;
    int               idx;

    function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    endfunction

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (k == KLAST);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + (1 - c_in); the inverted B is formed per digit.
    always_comb begin
        idx     = int'(k) * DIGIT;
        ad      = a_r[idx +: DIGIT];
        bd      = b_r[idx +: DIGIT] ^ {DIGIT{sub_r}};
        dsum    = digit_add(ad, bd, carry);
        msb_cin = ad[DIGIT-1] ^ bd[DIGIT-1] ^ dsum[DIGIT-1];
        res_nxt = res_r;
        res_nxt[idx +: DIGIT] = dsum[DIGIT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            sub_r    <= 1'b0;
            carry    <= 1'b0;
            k        <= '0;
            res_r    <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            carry <= c_in ^ sub;
            k     <= '0;
        end else if (state == RUN) begin
            res_r <= res_nxt;
            carry <= dsum[DIGIT];
            k     <= k + 1'b1;
            // Outputs change only here, so they hold through IDLE and RUN.
            if (last) begin
                sum      <= res_nxt;
                c_out    <= dsum[DIGIT];
                overflow <= msb_cin ^ dsum[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit vector table, multi-cycle corner
// sequences, and an exhaustive 4-bit sweep over three digit widths.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, c_in, sub;
    logic [7:0] a, b;
    logic       busy, done, c_out, overflow;
    logic [7:0] sum;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
        .sub(sub), .busy(busy), .done(done), .sum(sum), .c_out(c_out),
        .overflow(overflow)
    );

    logic [3:0] a4, b4;
    logic       cin4, sub4, start4;
    logic       busy4 [3];
    logic       done4 [3];
    logic [3:0] sum4  [3];
    logic       cout4 [3];
    logic       ovf4  [3];

    serial_adder #(.WIDTH(4), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(cin4),
        .sub(sub4), .busy(busy4[0]), .done(done4[0]), .sum(sum4[0]),
        .c_out(cout4[0]), .overflow(ovf4[0])
    );
    serial_adder #(.WIDTH(4), .DIGIT(2)) dut_d2 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(cin4),
        .sub(sub4), .busy(busy4[1]), .done(done4[1]), .sum(sum4[1]),
        .c_out(cout4[1]), .overflow(ovf4[1])
    );
    serial_adder #(.WIDTH(4), .DIGIT(4)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(cin4),
        .sub(sub4), .busy(busy4[2]), .done(done4[2]), .sum(sum4[2]),
        .c_out(cout4[2]), .overflow(ovf4[2])
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       cin, sub;
        logic [7:0] s;
        logic       co, ov;
    } vec_t;

    vec_t vecs [10];

    // One 8-bit operation; inputs are scrambled after acceptance.
    task automatic apply8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic ts, input logic [7:0] prev_sum,
                          output logic [7:0] rs, output logic rc, output logic ro,
                          output int lat);
        @(negedge clk);
        a = ta; b = tb; c_in = tc; sub = ts; start = 1'b1;
        lat = 0; rs = '0; rc = 1'b0; ro = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; a = ~ta; b = ~tb; c_in = ~tc; sub = ~ts;
                chk("busy_after_start", busy, 1'b1);
            end
            if (i == 3) chk("sum_hold_in_run", sum, prev_sum);
            chk("busy_done_exclusive", busy & done, 1'b0);
            if (done) begin
                lat = i; rs = sum; rc = c_out; ro = overflow;
            end
        end
        if (lat == 0) chk("done_timeout", 0, 1);
    endtask

    logic [7:0] rs, prev;
    logic       rc, ro;
    int         lat, d1, d2;
    int         full, ra, rb, r;
    logic [3:0] es;
    logic       eco, eov;
    int         l4 [3];
    logic [3:0] s4r [3];
    logic       c4r [3];
    logic       o4r [3];
    int         exp_lat [3] = '{5, 3, 2};

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
        vecs[7] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9] = '{8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", c_out, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        prev = 8'h00;
        for (int v = 0; v < 10; v++) begin
            apply8(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sub, prev, rs, rc, ro, lat);
            chk($sformatf("vec%0d_lat", v), lat, 9);
            chk($sformatf("vec%0d_sum", v), rs, vecs[v].s);
            chk($sformatf("vec%0d_cout", v), rc, vecs[v].co);
            chk($sformatf("vec%0d_ovf", v), ro, vecs[v].ov);
            prev = vecs[v].s;
        end

        // start held high through DONE: second op captured at the DONE edge
        @(negedge clk);
        a = 8'h01; b = 8'h01; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        d1 = 0; d2 = 0;
        for (int i = 1; i <= 30 && d2 == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin a = 8'hC0; b = 8'hA0; end
            chk("b2b_exclusive", busy & done, 1'b0);
            if (done && d1 == 0) begin
                d1 = i;
                chk("b2b_sum1", sum, 8'h02);
                chk("b2b_cout1", c_out, 1'b0);
            end else if (done) begin
                d2 = i;
                chk("b2b_sum2", sum, 8'h60);
                chk("b2b_cout2", c_out, 1'b1);
                chk("b2b_ovf2", overflow, 1'b1);
            end
            if (d1 != 0 && i == d1 + 1) begin
                start = 1'b0;
                chk("b2b_done_single", done, 1'b0);
                chk("b2b_busy_again", busy, 1'b1);
            end
        end
        chk("b2b_first_lat", d1, 9);
        chk("b2b_spacing", d2 - d1, 9);

        // reset mid-RUN aborts and clears outputs without a clock edge
        @(negedge clk);
        a = 8'hAA; b = 8'h11; start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_sum", sum, 8'h00);
        chk("abort_cout", c_out, 1'b0);
        chk("abort_ovf", overflow, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d1 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) d1 = 1;
        end
        chk("abort_no_done", d1, 0);
        apply8(8'h01, 8'h02, 1'b0, 1'b0, 8'h00, rs, rc, ro, lat);
        chk("post_rst_lat", lat, 9);
        chk("post_rst_sum", rs, 8'h03);

        // start pulsed 3 cycles into RUN with other operands is ignored
        @(negedge clk);
        a = 8'h0F; b = 8'h01; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 3) begin start = 1'b1; a = 8'h55; b = 8'h55; sub = 1'b1; c_in = 1'b1; end
            if (i == 4) start = 1'b0;
            if (done) begin
                lat = i;
                chk("ign_sum", sum, 8'h10);
                chk("ign_cout", c_out, 1'b0);
                chk("ign_ovf", overflow, 1'b0);
            end
        end
        chk("ign_lat", lat, 9);
        repeat (12) begin
            @(negedge clk);
            chk("ign_no_extra_done", done, 1'b0);
        end

        // exhaustive 4-bit sweep, DIGIT = 1, 2, 4 in parallel
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    for (int s = 0; s < 2; s++) begin
                        if (s != 0) full = x + ((~y) & 15) + (c ^ 1);
                        else        full = x + y + c;
                        es  = 4'(full);
                        eco = (full >= 16);
                        ra  = (x > 7) ? x - 16 : x;
                        rb  = (y > 7) ? y - 16 : y;
                        r   = (s != 0) ? ra - rb - c : ra + rb + c;
                        eov = (r > 7) || (r < -8);
                        @(negedge clk);
                        a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); sub4 = 1'(s); start4 = 1'b1;
                        for (int j = 0; j < 3; j++) l4[j] = 0;
                        for (int i = 1; i <= 8; i++) begin
                            @(negedge clk);
                            if (i == 1) begin start4 = 1'b0; a4 = ~a4; b4 = ~b4; end
                            for (int j = 0; j < 3; j++)
                                if (done4[j] && l4[j] == 0) begin
                                    l4[j] = i; s4r[j] = sum4[j]; c4r[j] = cout4[j]; o4r[j] = ovf4[j];
                                end
                        end
                        for (int j = 0; j < 3; j++) begin
                            chk($sformatf("sw%0d_a%0h_b%0h_c%0d_s%0d_lat", j, x, y, c, s), l4[j], exp_lat[j]);
                            chk($sformatf("sw%0d_a%0h_b%0h_c%0d_s%0d_sum", j, x, y, c, s), s4r[j], es);
                            chk($sformatf("sw%0d_a%0h_b%0h_c%0d_s%0d_cout", j, x, y, c, s), c4r[j], eco);
                            chk($sformatf("sw%0d_a%0h_b%0h_c%0d_s%0d_ovf", j, x, y, c, s), o4r[j], eov);
                        end
                    end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
